ifm_buf_rsp: RTL and testbench

- Responder end of the ifm address/data interface; sits between a read DMA's address stream and the on-chip ifm SRAM.
- Accepts addresses tagged with first/last and issues SRAM reads with fixed read latency.
- Returns read data with the same tags, in order, on a valid/ready data stream.
- Credit-limits address acceptance so no read data is ever dropped under output backpressure.

---
 rtl/ifm_buf_rsp.sv | 140 ++++++++++++++
 tb/tb_ifm_buf_rsp.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_buf_rsp.sv
// Responder for the ifm address/data interface: issues fixed-latency SRAM reads for
// tagged addresses and returns tagged data in order through a credit-limited FWFT FIFO.
module ifm_buf_rsp #(
  parameter int DW    = 64,
  parameter int AW    = 11,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m_addr,
  input  logic          m_addr_first,
  input  logic          m_addr_last,
  input  logic          m_addr_valid,
  output logic          m_addr_ready,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] s_data,
  output logic          s_data_first,
  output logic          s_data_last,
  output logic          s_data_valid,
  input  logic          s_data_ready,
  output logic          busy,
  output logic [15:0]   burst_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_S  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0] inflight;
  logic [CW-1:0] occ;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] addr_q;
  logic [LAT:1]  pipe_vld;
  logic [LAT:1]  pipe_first;
  logic [LAT:1]  pipe_last;
  logic [DW+1:0] fifo_mem [DEPTH];
  logic [DW+1:0] head;
  logic          credit_ok;
  logic          fire;
  logic          push;
  logic          pop;

  // Credit covers both reads still in the SRAM pipe and entries parked in the FIFO,
  // so every issued read is guaranteed a slot when its data returns.
  assign credit_ok    = ({1'b0, inflight} + {1'b0, occ}) < DEPTH_S;
  assign m_addr_ready = credit_ok & ~rst;
  assign fire         = m_addr_valid & m_addr_ready;

  assign mem_en   = fire;
  assign mem_addr = fire ? m_addr : addr_q;

  assign push = pipe_vld[LAT];
  assign pop  = s_data_valid & s_data_ready;

  assign s_data_valid = (occ != '0);
  assign head         = s_data_valid ? fifo_mem[rd_ptr] : '0;
  assign s_data       = head[DW+1:2];
  assign s_data_first = head[1];
  assign s_data_last  = head[0];

  assign busy = (inflight != '0) | (occ != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (fire) begin
      addr_q <= m_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld   <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_vld[1]   <= fire;
      pipe_first[1] <= m_addr_first;
      pipe_last[1]  <= m_addr_last;
      for (int k = 2; k <= LAT; k++) begin
        pipe_vld[k]   <= pipe_vld[k-1];
        pipe_first[k] <= pipe_first[k-1];
        pipe_last[k]  <= pipe_last[k-1];
      end
    end
  end

  // Storage needs no reset: the head is masked until occ says an entry is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {mem_rdata, pipe_first[LAT], pipe_last[LAT]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      occ      <= '0;
    end else begin
      case ({fire, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (pop && s_data_last) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ifm_buf_rsp.sv
// Bench for ifm_buf_rsp: SRAM model with fixed latency, scoreboard of tagged beats
// pushed on address fire and compared against output handshakes.
module tb_ifm_buf_rsp;
  localparam int DW    = 64;
  localparam int AW    = 11;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_addr_first = 1'b0;
  logic          m_addr_last = 1'b0;
  logic          m_addr_valid = 1'b0;
  logic          m_addr_ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] s_data;
  logic          s_data_first;
  logic          s_data_last;
  logic          s_data_valid;
  logic          s_data_ready = 1'b0;
  logic          busy;
  logic [15:0]   burst_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  logic fired;
  logic popped;
  logic [15:0] exp_bcnt;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] got_q[$];
  int got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifm_buf_rsp #(.DW(DW), .AW(AW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_addr_first(m_addr_first), .m_addr_last(m_addr_last),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .s_data(s_data), .s_data_first(s_data_first), .s_data_last(s_data_last),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return 64'hA5A5_0000_0000_0000 | DW'(a);
  endfunction

  // SRAM model; returns junk when not enabled so unqualified data is visible
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? sram_word(mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // one clock: record handshakes at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    fired  = m_addr_valid && m_addr_ready;
    popped = s_data_valid && s_data_ready;
    if (fired) exp_q.push_back({sram_word(m_addr), m_addr_first, m_addr_last});
    if (popped) begin
      got_q.push_back({s_data, s_data_first, s_data_last});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_addr_valid = 1'b1;
    s_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({m_addr_ready, mem_en, s_data_valid, s_data_first, s_data_last, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000",
               {m_addr_ready, mem_en, s_data_valid, s_data_first, s_data_last, busy});
    else pass_cnt++;
    total_cnt++;
    if (s_data !== '0) $display("FAIL reset_data: got %h expected 0", s_data);
    else pass_cnt++;
    total_cnt++;
    if (burst_cnt !== 16'd0) $display("FAIL reset_bcnt: got %h expected 0", burst_cnt);
    else pass_cnt++;
    m_addr_valid = 1'b0;
    rst = 1'b0;
    exp_bcnt = 16'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    m_addr = 11'h010; m_addr_first = 1'b1; m_addr_last = 1'b1;
    m_addr_valid = 1'b1; s_data_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_addr} !== {1'b1, 11'h010})
      $display("FAIL single_issue: got en=%b addr=%h expected en=1 addr=010", mem_en, mem_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    m_addr_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_addr, s_data_valid} !== {1'b0, 11'h010, 1'b0})
      $display("FAIL single_c1: got en=%b addr=%h vld=%b expected en=0 addr=010 vld=0",
               mem_en, mem_addr, s_data_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({s_data_valid, s_data, s_data_first, s_data_last} !== {1'b1, 64'hA5A5_0000_0000_0010, 2'b11})
      $display("FAIL single_data: got vld=%b data=%h f=%b l=%b expected vld=1 data=a5a5000000000010 f=1 l=1",
               s_data_valid, s_data, s_data_first, s_data_last);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    exp_bcnt = 16'd1;
    total_cnt++;
    if ({burst_cnt, busy} !== {exp_bcnt, 1'b0})
      $display("FAIL single_done: got bcnt=%h busy=%b expected bcnt=%h busy=0", burst_cnt, busy, exp_bcnt);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int i = 0;
    int drops = 0;
    int guard = 0;
    logic [DW+1:0] e, g;
    s_data_ready = 1'b1;
    while (i < 16 && guard < 100) begin
      m_addr = AW'(i); m_addr_first = (i == 0); m_addr_last = (i == 15); m_addr_valid = 1'b1;
      tick();
      if (fired) i++; else drops++;
      guard++;
    end
    m_addr_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 16 && guard < 100) begin tick(); guard++; end
    total_cnt++;
    if (drops !== 0) $display("FAIL stream_ready_drops: got %0d expected 0", drops);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== 16) $display("FAIL stream_count: got %0d expected 16", got_q.size());
    else pass_cnt++;
    if (got_cyc.size() == 16) begin
      total_cnt++;
      if (got_cyc[15] - got_cyc[0] !== 15)
        $display("FAIL stream_span: got %0d cycles expected 15", got_cyc[15] - got_cyc[0]);
      else pass_cnt++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL stream_beat: got %h expected %h", g, e);
      else pass_cnt++;
    end
    exp_bcnt = exp_bcnt + 16'd1;
    total_cnt++;
    if (burst_cnt !== exp_bcnt) $display("FAIL stream_bcnt: got %h expected %h", burst_cnt, exp_bcnt);
    else pass_cnt++;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int guard = 0;
    logic [DW+1:0] e, g;
    s_data_ready = 1'b0;
    repeat (10) begin
      m_addr = AW'(11'h100 + idx); m_addr_first = (idx == 0); m_addr_last = (idx == 7);
      m_addr_valid = 1'b1;
      tick();
      if (fired) idx++;
    end
    total_cnt++;
    if (idx !== 4) $display("FAIL bp_accepted: got %0d expected 4", idx);
    else pass_cnt++;
    total_cnt++;
    if ({m_addr_ready, s_data_valid, busy} !== 3'b011)
      $display("FAIL bp_stall: got rdy=%b vld=%b busy=%b expected rdy=0 vld=1 busy=1",
               m_addr_ready, s_data_valid, busy);
    else pass_cnt++;
    total_cnt++;
    if (dut.occ !== 3'd4) $display("FAIL bp_occ: got %0d expected 4", dut.occ);
    else pass_cnt++;
    s_data_ready = 1'b1;
    while (idx < 8 && guard < 100) begin
      m_addr = AW'(11'h100 + idx); m_addr_first = (idx == 0); m_addr_last = (idx == 7);
      m_addr_valid = 1'b1;
      tick();
      if (fired) idx++;
      guard++;
    end
    m_addr_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 8 && guard < 100) begin tick(); guard++; end
    total_cnt++;
    if (got_q.size() !== 8) $display("FAIL bp_count: got %0d expected 8", got_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL bp_beat: got %h expected %h", g, e);
      else pass_cnt++;
    end
    exp_bcnt = exp_bcnt + 16'd1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_random_ready();
    int i = 0;
    int guard = 0;
    logic [AW-1:0] cur;
    logic [DW+1:0] e, g;
    cur = AW'($urandom_range(0, 2047));
    while (i < 200 && guard < 2000) begin
      m_addr = cur; m_addr_first = (i % 10 == 0); m_addr_last = (i % 10 == 9);
      m_addr_valid = 1'b1;
      s_data_ready = 1'($urandom_range(0, 1));
      tick();
      if (fired) begin
        i++;
        cur = AW'($urandom_range(0, 2047));
      end
      guard++;
    end
    m_addr_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 200 && guard < 1000) begin
      s_data_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    s_data_ready = 1'b1;
    tick();
    total_cnt++;
    if (got_q.size() !== 200) $display("FAIL rand_count: got %0d expected 200", got_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL rand_beat: got %h expected %h", g, e);
      else pass_cnt++;
    end
    exp_bcnt = exp_bcnt + 16'd20;
    total_cnt++;
    if (burst_cnt !== exp_bcnt) $display("FAIL rand_bcnt: got %h expected %h", burst_cnt, exp_bcnt);
    else pass_cnt++;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [DW+1:0] e, g;
    s_data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_addr = AW'(11'h200 + k); m_addr_first = (k == 0); m_addr_last = 1'b0; m_addr_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({m_addr_ready, mem_en, s_data_valid, s_data_first, s_data_last, busy, burst_cnt, s_data} !== '0)
      $display("FAIL midrst_outputs: got rdy=%b en=%b vld=%b f=%b l=%b busy=%b bcnt=%h data=%h expected all zero",
               m_addr_ready, mem_en, s_data_valid, s_data_first, s_data_last, busy, burst_cnt, s_data);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    m_addr_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    exp_bcnt = 16'd0;
    s_data_ready = 1'b1;
    repeat (6) tick();
    total_cnt++;
    if ({got_q.size(), busy, burst_cnt} !== {32'd0, 1'b0, 16'd0})
      $display("FAIL midrst_stale: got beats=%0d busy=%b bcnt=%h expected beats=0 busy=0 bcnt=0",
               got_q.size(), busy, burst_cnt);
    else pass_cnt++;
    m_addr = 11'h2AB; m_addr_first = 1'b1; m_addr_last = 1'b1; m_addr_valid = 1'b1;
    tick();
    while (!fired && guard < 20) begin tick(); guard++; end
    m_addr_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 1 && guard < 20) begin tick(); guard++; end
    tick();
    total_cnt++;
    if (got_q.size() !== 1 || exp_q.size() !== 1)
      $display("FAIL midrst_new_count: got %0d beats expected 1", got_q.size());
    else pass_cnt++;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL midrst_new_beat: got %h expected %h", g, e);
      else pass_cnt++;
    end
    exp_bcnt = 16'd1;
    total_cnt++;
    if (burst_cnt !== exp_bcnt) $display("FAIL midrst_bcnt: got %h expected %h", burst_cnt, exp_bcnt);
    else pass_cnt++;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_wrap();
    int n;
    int cnt = 0;
    int guard = 0;
    n = 65535 - int'(exp_bcnt);
    s_data_ready = 1'b1;
    m_addr = 11'h3C3; m_addr_first = 1'b1; m_addr_last = 1'b1; m_addr_valid = 1'b1;
    while (cnt < n && guard < 70000) begin
      @(negedge clk);
      if (m_addr_valid && m_addr_ready) cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    m_addr_valid = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if (burst_cnt !== 16'hFFFF) $display("FAIL wrap_full: got %h expected ffff", burst_cnt);
    else pass_cnt++;
    m_addr_valid = 1'b1;
    tick();
    m_addr_valid = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if ({burst_cnt, busy} !== {16'h0000, 1'b0})
      $display("FAIL wrap_zero: got bcnt=%h busy=%b expected bcnt=0000 busy=0", burst_cnt, busy);
    else pass_cnt++;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
